// File: rtl/counter_preset_down.sv
// counter_preset_down: presettable synchronous down-counter / interval timer.
// Loads a preset (also kept as the reload value). It decrements on qualified
// count_en ticks while in RUN. A one-cycle borrow_out pulse marks each
// underflow. The counter then either reloads and keeps running (auto_reload=1)
// or parks at 0 in DONE (one-shot).
// Optional build macro COUNTER_PRESET_DOWN_UNDERFLOW_CNT_EN adds a saturating
// underflow_cnt output that counts borrow pulses and is cleared by load.
module counter_preset_down #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_preset,
  input  logic             start,
  input  logic             stop,
  input  logic             count_en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter_out,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef COUNTER_PRESET_DOWN_UNDERFLOW_CNT_EN
  ,
  output logic [WIDTH-1:0] underflow_cnt
`endif
);

  // Encoding 2'b11 is illegal and is steered back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             borrow_q, borrow_d;

  // State and datapath registers; async reset clears everything, including the reload value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
    end
  end

  // Next-state and datapath logic; priority is load > stop > start > count_en.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    borrow_d = 1'b0;
    if (load) begin
      // A load overrides everything, including an underflow in the same cycle.
      cnt_d    = data_preset;
      reload_d = data_preset;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (start) begin
            // Starting from zero expires immediately without a borrow.
            state_d = (cnt_q != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // Stop beats an underflow: no borrow, and the counter holds.
            state_d = ST_IDLE;
          end else if (count_en) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else begin
              // Underflow never wraps to all-ones: reload or park at zero.
              borrow_d = 1'b1;
              if (auto_reload) begin
                cnt_d = reload_q;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (start) begin
            cnt_d   = reload_q;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign counter_out = cnt_q;
  assign borrow_out  = borrow_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

`ifdef COUNTER_PRESET_DOWN_UNDERFLOW_CNT_EN
  logic [WIDTH-1:0] uf_q, uf_d;

  // Underflow tally: bumps together with each borrow pulse, saturates, and is cleared by load.
  always_comb begin
    uf_d = uf_q;
    if (load) begin
      uf_d = '0;
    end else if (borrow_d && (uf_q != '1)) begin
      uf_d = uf_q + WIDTH'(1);
    end
  end

  // Underflow tally register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_q <= '0;
    end else begin
      uf_q <= uf_d;
    end
  end

  assign underflow_cnt = uf_q;
`endif

endmodule

// File: tb/tb_counter_preset_down.sv
// Scoreboard bench for counter_preset_down: the driver updates a reference model
// and queues the expected outputs for each cycle. A monitor compares them one
// cycle later, just after the clock edge.
module tb_counter_preset_down;
  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] data_preset = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             count_en = 1'b0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] counter_out;
  logic             borrow_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] got_uf;

`ifdef COUNTER_PRESET_DOWN_UNDERFLOW_CNT_EN
  logic [WIDTH-1:0] uf_cnt;
  assign got_uf = uf_cnt;
`else
  assign got_uf = '0;
`endif

  counter_preset_down #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data_preset (data_preset),
    .start       (start),
    .stop        (stop),
    .count_en    (count_en),
    .auto_reload (auto_reload),
    .counter_out (counter_out),
    .borrow_out  (borrow_out),
    .busy        (busy),
`ifdef COUNTER_PRESET_DOWN_UNDERFLOW_CNT_EN
    .underflow_cnt (uf_cnt),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             borrow;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] uf;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: timer mode, current count, reload value, underflow tally.
  int m_mode = M_IDLE;
  int m_cnt  = 0;
  int m_rel  = 0;
  int m_bor  = 0;
  int m_uf   = 0;

  function automatic void model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_rel = 0; m_bor = 0; m_uf = 0;
  endfunction

  function automatic void model_step(input int l, input int dp, input int s,
                                     input int p, input int e, input int a);
    m_bor = 0;
    if (l != 0) begin
      m_cnt = dp; m_rel = dp; m_mode = M_IDLE; m_uf = 0;
    end else if (p != 0) begin
      m_mode = M_IDLE;
    end else if (s != 0 && m_mode == M_IDLE) begin
      m_mode = (m_cnt > 0) ? M_RUN : M_DONE;
    end else if (s != 0 && m_mode == M_DONE) begin
      m_cnt = m_rel; m_mode = M_RUN;
    end else if (e != 0 && m_mode == M_RUN) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end else begin
        m_bor = 1;
        if (m_uf < MAXV) m_uf = m_uf + 1;
        if (a != 0) m_cnt = m_rel;
        else m_mode = M_DONE;
      end
    end
  endfunction

  // One stimulus cycle: drive at the falling edge, then queue what the next rising edge must produce.
  task automatic cycle(input string nm, input logic l, input logic [WIDTH-1:0] dp,
                       input logic s, input logic p, input logic e, input logic a);
    exp_t x;
    @(negedge clk);
    load = l; data_preset = dp; start = s; stop = p; count_en = e; auto_reload = a;
    model_step(int'(l), int'(dp), int'(s), int'(p), int'(e), int'(a));
    x.cnt    = WIDTH'(m_cnt);
    x.borrow = (m_bor != 0);
    x.busy   = (m_mode == M_RUN);
    x.done   = (m_mode == M_DONE);
`ifdef COUNTER_PRESET_DOWN_UNDERFLOW_CNT_EN
    x.uf     = WIDTH'(m_uf);
`else
    x.uf     = '0;
`endif
    sb_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    load = 0; start = 0; stop = 0; count_en = 0; auto_reload = 0; data_preset = '0;
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if (counter_out !== '0 || borrow_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || got_uf !== '0) begin
      errors++;
      $display("FAIL %s: got cnt=%0d borrow=%b busy=%b done=%b uf=%0d, expected all zero",
               nm, counter_out, borrow_out, busy, done, got_uf);
    end else begin
      $display("ok   %s: outputs cleared", nm);
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare it against the oldest queued expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (counter_out !== e.cnt || borrow_out !== e.borrow || busy !== e.busy ||
            done !== e.done || got_uf !== e.uf) begin
          errors++;
          $display("FAIL %s: got cnt=%0d borrow=%b busy=%b done=%b uf=%0d, expected cnt=%0d borrow=%b busy=%b done=%b uf=%0d",
                   nm, counter_out, borrow_out, busy, done, got_uf,
                   e.cnt, e.borrow, e.busy, e.done, e.uf);
        end else begin
          $display("ok   %s: cnt=%0d borrow=%b busy=%b done=%b uf=%0d",
                   nm, counter_out, borrow_out, busy, done, got_uf);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Preset 5 lands in IDLE.
    cycle("preset5", 1, 4'd5, 0, 0, 0, 0);
    cycle("preset5_hold", 0, 4'd0, 0, 0, 1, 0);

    // One-shot from 3: 3,2,1,0 then borrow and DONE; further ticks are ignored.
    cycle("os_load3", 1, 4'd3, 0, 0, 0, 0);
    cycle("os_start", 0, 4'd0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle("os_tick", 0, 4'd0, 0, 0, 1, 0);

    // Auto-reload from 2, nine ticks: borrow on ticks 3, 6, 9.
    cycle("ar_load2", 1, 4'd2, 0, 0, 0, 1);
    cycle("ar_start", 0, 4'd0, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) cycle("ar_tick", 0, 4'd0, 0, 0, 1, 1);

    // Stop beats start; a later start resumes from the held value.
    cycle("ss_load7", 1, 4'd7, 0, 0, 0, 0);
    cycle("ss_start", 0, 4'd0, 1, 0, 0, 0);
    cycle("ss_tick", 0, 4'd0, 0, 0, 1, 0);
    cycle("ss_tick", 0, 4'd0, 0, 0, 1, 0);
    cycle("ss_stop_start", 0, 4'd0, 1, 1, 1, 0);
    cycle("ss_resume", 0, 4'd0, 1, 0, 0, 0);
    cycle("ss_tick", 0, 4'd0, 0, 0, 1, 0);

    // Load wins over an underflow in the same cycle.
    cycle("lu_load1", 1, 4'd1, 0, 0, 0, 1);
    cycle("lu_start", 0, 4'd0, 1, 0, 0, 1);
    cycle("lu_tick", 0, 4'd0, 0, 0, 1, 1);
    cycle("lu_load9", 1, 4'd9, 0, 0, 1, 1);

    // Stop wins over an underflow: no borrow, counter holds 0.
    cycle("su_start", 0, 4'd0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle("su_tick", 0, 4'd0, 0, 0, 1, 0);
    cycle("su_stop", 0, 4'd0, 0, 1, 1, 0);

    // Reload 0 with auto-reload borrows on every tick.
    cycle("z_load0", 1, 4'd0, 0, 0, 0, 1);
    cycle("z_start_done", 0, 4'd0, 1, 0, 0, 1);
    cycle("z_restart", 0, 4'd0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle("z_tick", 0, 4'd0, 0, 0, 1, 1);

    // Async reset mid-count at 6, then start with 0 goes straight to DONE.
    cycle("rs_load9", 1, 4'd9, 0, 0, 0, 0);
    cycle("rs_start", 0, 4'd0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("rs_tick", 0, 4'd0, 0, 0, 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero("async_reset");
    idle_inputs();
    rst_n = 1'b1;
    cycle("rs_start0", 0, 4'd0, 1, 0, 1, 0);
    cycle("rs_done_hold", 0, 4'd0, 0, 0, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            logic'($urandom_range(0, 15) == 0),
            WIDTH'($urandom),
            logic'($urandom_range(0, 4) == 0),
            logic'($urandom_range(0, 11) == 0),
            logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)));
    end

    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
